// File: rtl/text_pkg.sv
// Shared definitions for the text screen path: tile geometry, buffer
// address widths, the clear character and the write-arbiter states.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int TILES  = COLS * ROWS;
  localparam int ADDR_W = 12;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;

  localparam logic [7:0] BLANK = 8'h20;

  typedef enum logic {
    IDLE,
    CLEAR
  } arb_state_e;

endpackage

// File: rtl/text_write_arbiter_if.sv
// Client-side and buffer-side signals of the text write arbiter. The
// master modport is the client/test side, slave is the arbiter.
interface text_write_arbiter_if
  import text_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CHAR_W  = 8
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ROW_W-1:0]  req_row;
  logic [NUM_REQ*COL_W-1:0]  req_col;
  logic [NUM_REQ*CHAR_W-1:0] req_char;
  logic [NUM_REQ-1:0]        grant;
  logic                      clear_req;
  logic                      clear_busy;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [CHAR_W-1:0]         wr_data;
  logic                      range_err;

  modport master (
    output req, req_row, req_col, req_char, clear_req,
    input  grant, clear_busy, wr_en, wr_addr, wr_data, range_err
  );

  modport slave (
    input  req, req_row, req_col, req_char, clear_req,
    output grant, clear_busy, wr_en, wr_addr, wr_data, range_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last_grant+1 upward,
// wrapping, over requests not masked by the previous grant.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] winner
);

  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   idx;
  logic               found;

  assign eligible = req & ~mask;

  // First eligible client in rotating priority order wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k + 1) % NUM_REQ);
      if (!found && eligible[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_write_arbiter.sv
// Write-side controller for the character screen buffer: round-robin
// arbitration between display clients, tile-to-linear address mapping,
// and a full-screen clear sweep that pre-empts client writes.
module text_write_arbiter
  import text_pkg::*;
#(
  parameter int               NUM_REQ = 4,
  parameter int               COLS    = text_pkg::COLS,
  parameter int               ROWS    = text_pkg::ROWS,
  parameter int               CHAR_W  = 8,
  parameter logic [CHAR_W-1:0] BLANK  = text_pkg::BLANK
) (
  input  logic                 clk,
  input  logic                 reset_n,
  text_write_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);

  arb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   clear_addr_q, clear_addr_d;
  logic [NUM_REQ-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [CHAR_W-1:0]   wr_data_q, wr_data_d;
  logic                clear_busy_q, clear_busy_d;
  logic                range_err_q, range_err_d;

  logic [NUM_REQ-1:0]  winner;
  logic [IDX_W-1:0]    win_idx;
  logic [ROW_W-1:0]    win_row;
  logic [COL_W-1:0]    win_col;
  logic [CHAR_W-1:0]   win_char;
  logic [ADDR_W-1:0]   win_addr;
  logic                win_in_range;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req),
    .mask       (mask_q),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  // Select the winning client's index and payload from the packed buses.
  always_comb begin
    // NOTE: every always_comb target gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    win_idx  = '0;
    win_row  = '0;
    win_col  = '0;
    win_char = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        win_idx  = IDX_W'(i);
        win_row  = bus.req_row[i*ROW_W +: ROW_W];
        win_col  = bus.req_col[i*COL_W +: COL_W];
        win_char = bus.req_char[i*CHAR_W +: CHAR_W];
      end
    end
  end

  // Tile to linear address; 80 columns reduces to two shifts and an add.
  generate
    if (COLS == 80) begin : g_addr_shift
      assign win_addr = (ADDR_W'(win_row) << 6) + (ADDR_W'(win_row) << 4)
                      + ADDR_W'(win_col);
    end else begin : g_addr_mult
      assign win_addr = ADDR_W'(win_row) * ADDR_W'(COLS) + ADDR_W'(win_col);
    end
  endgenerate

  assign win_in_range = (win_row < ROW_W'(ROWS)) && (win_col < COL_W'(COLS));

  // Next-state and next-output logic for the IDLE/CLEAR controller.
  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    mask_d       = mask_q;
    last_grant_d = last_grant_q;
    grant_d      = '0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    clear_busy_d = 1'b0;
    range_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d      = CLEAR;
          clear_addr_d = '0;
          mask_d       = '0;
          clear_busy_d = 1'b1;
          wr_en_d      = 1'b1;
          wr_addr_d    = '0;
          wr_data_d    = BLANK;
        end else if (|winner) begin
          grant_d      = winner;
          last_grant_d = win_idx;
          mask_d       = winner;
          if (win_in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = win_addr;
            wr_data_d = win_char;
          end else begin
            range_err_d = 1'b1;
          end
        end else begin
          mask_d = '0;
        end
      end

      CLEAR: begin
        mask_d = '0;
        // clear_addr tracks the address on the write port this cycle.
        if (clear_addr_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
          clear_busy_d = 1'b1;
          wr_en_d      = 1'b1;
          wr_addr_d    = clear_addr_q + 1'b1;
          wr_data_d    = BLANK;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clear_addr_q <= '0;
      mask_q       <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      clear_busy_q <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      mask_q       <= mask_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      clear_busy_q <= clear_busy_d;
      range_err_q  <= range_err_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.clear_busy = clear_busy_q;
  assign bus.range_err  = range_err_q;

endmodule

// File: tb/tb_text_write_arbiter.sv
// Self-checking bench for text_write_arbiter: a table of single-shot
// requests followed by hand-written rotation, throughput, clear and
// mid-sweep reset sequences.
module tb_text_write_arbiter;

  logic clk;
  logic reset_n;
  int   tests;
  int   failed;

  text_write_arbiter_if #(.NUM_REQ(4), .CHAR_W(8)) bus ();

  text_write_arbiter #(.NUM_REQ(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  req;
    logic [4:0]  row;
    logic [6:0]  col;
    logic [7:0]  ch;
    logic [3:0]  exp_grant;
    logic        exp_en;
    logic [11:0] exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int i, input logic [4:0] r,
                            input logic [6:0] c, input logic [7:0] ch);
    bus.req_row[i*5 +: 5]  = r;
    bus.req_col[i*7 +: 7]  = c;
    bus.req_char[i*8 +: 8] = ch;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.clear_req = 1'b0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.req_char  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_grant"},      bus.grant, 0);
    check({tag, "_wr_en"},      bus.wr_en, 0);
    check({tag, "_wr_addr"},    bus.wr_addr, 0);
    check({tag, "_wr_data"},    bus.wr_data, 0);
    check({tag, "_clear_busy"}, bus.clear_busy, 0);
    check({tag, "_range_err"},  bus.range_err, 0);
  endtask

  initial begin
    int k;
    int idx;
    int bad;
    int busy_cycles;
    int waited;

    tests  = 0;
    failed = 0;

    // row, col, char are given to every requesting client of the vector.
    vecs[0] = '{4'b0010, 5'd2,  7'd5,   8'h41, 4'b0010, 1'b1, 12'd165,  1'b0};
    vecs[1] = '{4'b1001, 5'd29, 7'd79,  8'h7E, 4'b1000, 1'b1, 12'd2399, 1'b0};
    vecs[2] = '{4'b0101, 5'd0,  7'd0,   8'h55, 4'b0001, 1'b1, 12'd0,    1'b0};
    vecs[3] = '{4'b0100, 5'd30, 7'd10,  8'h33, 4'b0100, 1'b0, 12'd0,    1'b1};
    vecs[4] = '{4'b1001, 5'd1,  7'd0,   8'h61, 4'b1000, 1'b1, 12'd80,   1'b0};
    vecs[5] = '{4'b0010, 5'd5,  7'd80,  8'h00, 4'b0010, 1'b0, 12'd0,    1'b1};
    vecs[6] = '{4'b1111, 5'd10, 7'd40,  8'h2A, 4'b0100, 1'b1, 12'd840,  1'b0};
    vecs[7] = '{4'b0011, 5'd29, 7'd0,   8'h4D, 4'b0001, 1'b1, 12'd2320, 1'b0};
    vecs[8] = '{4'b0000, 5'd0,  7'd0,   8'h00, 4'b0000, 1'b0, 12'd0,    1'b0};
    vecs[9] = '{4'b0001, 5'd31, 7'd127, 8'hFF, 4'b0001, 1'b0, 12'd0,    1'b1};

    // Reset values while reset is held.
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.clear_req = 1'b0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.req_char  = '0;
    #12;
    check_outputs_zero("reset");
    do_reset();

    // Table of single-shot requests; round-robin state carries across rows.
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 4; i++) set_client(i, vecs[n].row, vecs[n].col, vecs[n].ch);
      bus.req = vecs[n].req;
      tick();
      check($sformatf("vec%0d_grant", n), bus.grant, vecs[n].exp_grant);
      check($sformatf("vec%0d_wr_en", n), bus.wr_en, vecs[n].exp_en);
      check($sformatf("vec%0d_range_err", n), bus.range_err, vecs[n].exp_err);
      if (vecs[n].exp_en) begin
        check($sformatf("vec%0d_wr_addr", n), bus.wr_addr, vecs[n].exp_addr);
        check($sformatf("vec%0d_wr_data", n), bus.wr_data, vecs[n].ch);
      end
      bus.req = '0;
      tick();
      check($sformatf("vec%0d_idle_grant", n), bus.grant, 0);
      check($sformatf("vec%0d_idle_wr_en", n), bus.wr_en, 0);
    end

    // All four clients request continuously: grants rotate 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) set_client(i, 5'(i), 7'(i + 1), 8'(8'h30 + i));
    bus.req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("rot%0d_grant", c), bus.grant, 4'b0001 << (c % 4));
      check($sformatf("rot%0d_wr_addr", c), bus.wr_addr, (c % 4) * 80 + (c % 4) + 1);
      check($sformatf("rot%0d_wr_data", c), bus.wr_data, 8'h30 + (c % 4));
    end
    bus.req = '0;
    tick();

    // One client holding req with a fresh payload per grant: every other cycle.
    do_reset();
    k = 0;
    set_client(0, 5'(k + 1), 7'(2 * k + 3), 8'(8'h60 + k));
    bus.req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 2 == 1) begin
        check($sformatf("thru%0d_grant", c), bus.grant, 4'b0001);
        check($sformatf("thru%0d_wr_addr", c), bus.wr_addr, (k + 1) * 80 + 2 * k + 3);
        check($sformatf("thru%0d_wr_data", c), bus.wr_data, 8'h60 + k);
        k++;
        if (k < 4) set_client(0, 5'(k + 1), 7'(2 * k + 3), 8'(8'h60 + k));
        else bus.req = '0;
      end else begin
        check($sformatf("thru%0d_no_grant", c), bus.grant, 0);
        check($sformatf("thru%0d_no_write", c), bus.wr_en, 0);
      end
    end
    tick();
    check("thru_after_grant", bus.grant, 0);

    // Clear together with req[0]: full sweep first, then the client write.
    do_reset();
    set_client(0, 5'd3, 7'd4, 8'h5A);
    bus.req       = 4'b0001;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    idx         = 0;
    bad         = 0;
    busy_cycles = 0;
    while (bus.clear_busy && busy_cycles < 2500) begin
      if (!(bus.wr_en === 1'b1 && bus.wr_addr === 12'(idx) &&
            bus.wr_data === 8'h20 && bus.grant === 4'b0000))
        bad++;
      idx++;
      busy_cycles++;
      // A clear_req pulse mid-sweep must not restart it.
      if (idx == 500) bus.clear_req = 1'b1;
      if (idx == 510) bus.clear_req = 1'b0;
      tick();
    end
    check("clear_busy_cycles", busy_cycles, 2400);
    check("clear_bad_writes", bad, 0);
    check("post_clear_wr_en", bus.wr_en, 0);
    check("post_clear_grant", bus.grant, 0);
    tick();
    check("post_clear_req_grant", bus.grant, 4'b0001);
    check("post_clear_req_wr_en", bus.wr_en, 1);
    check("post_clear_req_addr", bus.wr_addr, 244);
    check("post_clear_req_data", bus.wr_data, 8'h5A);
    bus.req = '0;
    tick();

    // Reset mid-sweep at address 1000: outputs drop at once, no resume.
    do_reset();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    waited = 0;
    while (bus.wr_addr !== 12'd1000 && waited < 1100) begin
      tick();
      waited++;
    end
    check("sweep_reached_1000", bus.wr_addr, 1000);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midsweep_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check("no_resume_busy", bus.clear_busy, 0);
    check("no_resume_wr_en", bus.wr_en, 0);
    for (int i = 0; i < 4; i++) set_client(i, 5'd0, 7'd7, 8'(8'h5A + i));
    bus.req = 4'b1111;
    tick();
    check("after_reset_grant", bus.grant, 4'b0001);
    check("after_reset_addr", bus.wr_addr, 7);
    check("after_reset_data", bus.wr_data, 8'h5A);
    bus.req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/text_write_arbiter.md
# text_write_arbiter

Write-side controller for the 80x30 character screen buffer that the VGA text path reads through its pixel-to-tile mapping. It arbitrates round-robin between NUM_REQ display clients (sensor readouts, status lines, menus), each writing one character at (row, col). It converts tile coordinates to a linear buffer address and drives a single write port. It also sequences a full-screen clear sweep that has priority over client writes.

## Interface
Parameters:
- NUM_REQ, 4: number of write clients.
- COLS, 80: tile columns per row.
- ROWS, 30: tile rows.
- CHAR_W, 8: character code width.
- BLANK, 8'h20: code written by a clear.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous and active-low (one clock; reset is asynchronous and active-low).
- req  in  NUM_REQ  per-client write request (level).
- req_row  in  NUM_REQ*5  packed tile row per client, client i at [5i+4:5i].
- req_col  in  NUM_REQ*7  packed tile column per client.
- req_char  in  NUM_REQ*CHAR_W  packed character code per client.
- grant  out  NUM_REQ  one-hot, one-cycle pulse; consumes the client's request.
- clear_req  in  1  start full-screen clear (level, sampled in IDLE).
- clear_busy  out  1  high for the whole sweep.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  12  linear address = row*COLS + col.
- wr_data  out  CHAR_W  character to write.
- range_err  out  1  one-cycle pulse when the granted request is out of range.

## Operation
- States: IDLE, CLEAR.
- IDLE, clear_req=1 at an edge: enter CLEAR. Set clear_addr=0. No grant on that edge, even if req is pending.
- IDLE, clear_req=0, any eligible req: pick the winner round-robin, starting at last_grant+1 and wrapping modulo NUM_REQ.
  - Register grant[w]=1 and latch that client's payload.
  - In the same cycle, drive wr_en=1, wr_addr=row*COLS+col, wr_data=char.
  - Compute the address as (row<<6)+(row<<4)+col when COLS=80; otherwise use a generic constant multiply. Width is 12 bits; max is 2399.
- Eligibility: a client granted in the current cycle is masked for the next arbitration edge, so a still-high req is never granted twice. Per-client throughput is 1 write per 2 cycles; aggregate throughput is 1 write per cycle.
- Out of range (row>=ROWS or col>=COLS): still grant (request consumed) and still update last_grant. Drive wr_en=0 and range_err=1.
- CLEAR:
  - Each cycle: wr_en=1, wr_addr=clear_addr, wr_data=BLANK, clear_busy=1; then clear_addr increments.
  - After writing address ROWS*COLS-1 (2399), return to IDLE. clear_busy falls on that same edge.
  - grant=0 throughout. clear_req is ignored while in CLEAR (no restart).
  - Pending reqs wait and are arbitrated from the first IDLE edge.
- last_grant resets to NUM_REQ-1, so client 0 has first priority.

## Timing
- Reset values: grant=0, wr_en=0, wr_addr=0, wr_data=0, clear_busy=0, range_err=0; state=IDLE, last_grant=NUM_REQ-1, clear_addr=0, mask=0.
- All outputs are registered; none are combinational from inputs.
- Write latency: req high at edge N gives grant, wr_en, wr_addr and wr_data valid in cycle N+1 (between edges N and N+1).
- Client protocol:
  - Hold req and payload stable until grant is seen high.
  - Deassert req, or present the next payload, on the edge ending the grant cycle.
- Clear duration: clear_req at edge N gives clear_busy high from N+1 through N+2400. There are exactly 2400 wr_en cycles, addresses 0..2399 in order.
- clear_req and req at the same IDLE edge: clear wins; req is serviced after the sweep.
- reset_n low at any time, including mid-sweep or during a grant cycle: outputs go to reset values immediately. The sweep is abandoned with no resume.

## Structure
- Shared package text_pkg: COLS, ROWS, TILES=2400, ADDR_W=12, ROW_W=5, COL_W=7, BLANK, and the state encoding (IDLE, CLEAR). The same package is used by the tile-mapping and scanout blocks.
- One sub-module, rr_arbiter (NUM_REQ): inputs req, mask and last_grant; output one-hot winner, combinational. The parent registers the winner.

## Test plan
- Reset, then client 1 requests (row=2, col=5, char=8'h41) -> one cycle later grant=4'b0010, wr_en=1, wr_addr=165, wr_data=8'h41; a single write only.
- All 4 clients hold req continuously -> grants rotate 0,1,2,3,0 on consecutive cycles; no client is granted twice in a row.
- Single client holds req high with a new payload each grant -> writes occur every other cycle, no duplicates.
- clear_req pulse together with req[0] -> 2400 writes of 8'h20 at addresses 0..2399, clear_busy high for 2400 cycles; then grant[0] with the client-0 write.
- Client 2 requests row=30, col=10 -> grant[2]=1, range_err=1, wr_en=0; the next request from client 3 has priority.
- reset_n pulsed low at clear_addr=1000 -> all outputs 0 immediately; after release a new request is handled normally with client-0-first priority.
